// File: rtl/evm_pkg.sv
// Shared definitions for the EVM ballot controller: sequencer states,
// default sizing and the one-hot qualification helper.
package evm_pkg;

    localparam int unsigned EVM_N_CAND      = 4;
    localparam int unsigned EVM_CNT_W       = 4;
    localparam int unsigned EVM_HOLD_CYCLES = 3;
    localparam int unsigned EVM_ACK_CYCLES  = 4;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        CAST,
        ACK,
        RELEASE
    } evm_state_t;

    // True when exactly one bit is set; callers zero-extend narrower vectors.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/evm_tally_counter.sv
// Per-candidate tally: synchronous clear, single-step enable, saturates at
// all-ones instead of wrapping.
module evm_tally_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    assign full = (count == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Ballot sequencer: one ballot per officer authorisation, debounced one-hot
// candidate selection, a single tally enable per ballot, and result read-back.
module evm_ballot_ctrl
    import evm_pkg::*;
#(
    parameter int unsigned N_CAND      = EVM_N_CAND,
    parameter int unsigned CNT_W       = EVM_CNT_W,
    parameter int unsigned HOLD_CYCLES = EVM_HOLD_CYCLES,
    parameter int unsigned ACK_CYCLES  = EVM_ACK_CYCLES,
    parameter int unsigned SEL_W       = $clog2(N_CAND),
    parameter int unsigned TOT_W       = CNT_W + $clog2(N_CAND)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ballot_en,
    input  logic [N_CAND-1:0] vote_btn,
    input  logic              result_mode,
    input  logic [SEL_W-1:0]  result_sel,
    output logic              ready,
    output logic              vote_ack,
    output logic              invalid,
    output logic [N_CAND-1:0] cand_full,
    output logic [CNT_W-1:0]  result_count,
    output logic [TOT_W-1:0]  total_votes
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned ACK_W  = $clog2(ACK_CYCLES + 1);

    evm_state_t        state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic [ACK_W-1:0]  ack_cnt, ack_next;
    logic [SEL_W-1:0]  cand_idx, cand_idx_next;
    logic [N_CAND-1:0] prev_btn;
    logic [N_CAND-1:0] tally_en;
    logic [CNT_W-1:0]  tally [N_CAND];
    logic [TOT_W-1:0]  tally_sum;

    logic              btn_zero;
    logic              btn_onehot;
    logic              btn_hits_full;
    logic              btn_valid;
    logic [SEL_W-1:0]  btn_idx;

    for (genvar g = 0; g < N_CAND; g++) begin : g_tally
        evm_tally_counter #(
            .CNT_W (CNT_W)
        ) u_tally (
            .clk   (clk),
            .reset (reset),
            .en    (tally_en[g]),
            .count (tally[g]),
            .full  (cand_full[g])
        );
    end

    assign btn_zero      = (vote_btn == '0);
    assign btn_onehot    = is_onehot(32'(vote_btn));
    assign btn_hits_full = |(vote_btn & cand_full);
    assign btn_valid     = btn_onehot && !btn_hits_full;

    always_comb begin
        btn_idx = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            if (vote_btn[i]) begin
                btn_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ack_cnt  <= '0;
            cand_idx <= '0;
            prev_btn <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            ack_cnt  <= ack_next;
            cand_idx <= cand_idx_next;
            prev_btn <= vote_btn;
        end
    end

    always_comb begin
        state_next    = state;
        hold_next     = '0;
        ack_next      = '0;
        cand_idx_next = cand_idx;
        tally_en      = '0;
        unique case (state)
            IDLE: begin
                if (ballot_en && btn_zero) begin
                    state_next = READY;
                end
            end
            READY: begin
                // A non-zero hold count implies last cycle's pattern was already qualified.
                if (btn_valid) begin
                    if ((hold_cnt != '0) && (vote_btn == prev_btn)) begin
                        hold_next = hold_cnt + 1'b1;
                    end else begin
                        hold_next = HOLD_W'(1);
                    end
                    if (hold_next == HOLD_W'(HOLD_CYCLES)) begin
                        state_next    = CAST;
                        cand_idx_next = btn_idx;
                        hold_next     = '0;
                    end
                end
            end
            CAST: begin
                tally_en[cand_idx] = 1'b1;
                state_next         = ACK;
            end
            ACK: begin
                if (ack_cnt == ACK_W'(ACK_CYCLES - 1)) begin
                    state_next = RELEASE;
                end else begin
                    ack_next = ack_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (btn_zero) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready    = (state == READY);
    assign vote_ack = (state == ACK);
    assign invalid  = (state == READY) &&
                      ((!btn_zero && !btn_onehot) || (btn_onehot && btn_hits_full));

    always_comb begin
        result_count = '0;
        if ((state == IDLE) && result_mode && (32'(result_sel) < N_CAND)) begin
            result_count = tally[result_sel];
        end
    end

    always_comb begin
        tally_sum = '0;
        for (int unsigned i = 0; i < N_CAND; i++) begin
            tally_sum = tally_sum + TOT_W'(tally[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_votes <= '0;
        end else begin
            total_votes <= tally_sum;
        end
    end

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed bench for evm_ballot_ctrl; completed votes are checked through a
// scoreboard queue drained by a monitor watching the acknowledge pulse.
module tb_evm_ballot_ctrl;

    localparam int unsigned N_CAND = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HOLD   = 3;
    localparam int unsigned ACKC   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ballot_en = 1'b0;
    logic [3:0] vote_btn = '0;
    logic       result_mode = 1'b0;
    logic [1:0] result_sel = '0;
    logic       ready;
    logic       vote_ack;
    logic       invalid;
    logic [3:0] cand_full;
    logic [3:0] result_count;
    logic [5:0] total_votes;

    int          total_checks = 0;
    int          bad_checks = 0;
    int unsigned model [4];
    int unsigned exp_q [$];

    always #5 clk = ~clk;

    evm_ballot_ctrl #(
        .N_CAND      (N_CAND),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD),
        .ACK_CYCLES  (ACKC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ballot_en    (ballot_en),
        .vote_btn     (vote_btn),
        .result_mode  (result_mode),
        .result_sel   (result_sel),
        .ready        (ready),
        .vote_ack     (vote_ack),
        .invalid      (invalid),
        .cand_full    (cand_full),
        .result_count (result_count),
        .total_votes  (total_votes)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int unsigned model_sum();
        int unsigned s = 0;
        for (int i = 0; i < 4; i++) s += model[i];
        return s;
    endfunction

    task automatic push_vote(input int idx);
        if (model[idx] < 15) model[idx]++;
        exp_q.push_back(model_sum());
    endtask

    task automatic read_tally(input int sel, input int unsigned exp);
        result_mode = 1'b1;
        result_sel  = 2'(sel);
        #1;
        check($sformatf("result_count[%0d]", sel), 32'(result_count), exp);
        result_mode = 1'b0;
    endtask

    task automatic open_ballot();
        ballot_en = 1'b1;
        vote_btn  = '0;
        step(1);
        ballot_en = 1'b0;
        check("ready_open", 32'(ready), 1);
    endtask

    // Entered in the CAST cycle; leaves in IDLE unless the button is kept held.
    task automatic finish_vote(input bit keep);
        step(1 + ACKC);
        if (!keep) begin
            vote_btn = '0;
            step(1);
        end
    endtask

    task automatic do_vote(input logic [3:0] b, input int idx);
        open_ballot();
        vote_btn = b;
        #1;
        check("invalid_low", 32'(invalid), 0);
        push_vote(idx);
        step(HOLD);
        finish_vote(1'b0);
    endtask

    initial begin : monitor
        int unsigned run;
        logic        prev;
        int unsigned exp_total;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (vote_ack) begin
                    run++;
                end else if (prev) begin
                    if (exp_q.size() == 0) begin
                        total_checks++;
                        bad_checks++;
                        $display("FAIL unexpected_ack: got ack run %0d expected none at %0t", run, $time);
                    end else begin
                        exp_total = exp_q.pop_front();
                        check("ack_len", run, ACKC);
                        check("total_after_vote", 32'(total_votes), exp_total);
                    end
                    run = 0;
                end
                prev = vote_ack;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        for (int i = 0; i < 4; i++) model[i] = 0;

        // Reset state
        step(2);
        check("rst_ready", 32'(ready), 0);
        check("rst_vote_ack", 32'(vote_ack), 0);
        check("rst_cand_full", 32'(cand_full), 0);
        check("rst_total", 32'(total_votes), 0);
        reset = 1'b0;
        step(1);
        read_tally(0, 0);

        // Basic vote on candidate 1
        do_vote(4'b0010, 1);
        read_tally(1, 1);

        // Multi-hot never casts; read-back blocked outside IDLE
        open_ballot();
        vote_btn = 4'b0110;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("multihot_invalid", 32'(invalid), 1);
            check("multihot_ready", 32'(ready), 1);
            step(1);
        end
        result_mode = 1'b1;
        result_sel  = 2'd1;
        #1;
        check("result_outside_idle", 32'(result_count), 0);
        result_mode = 1'b0;
        vote_btn = 4'b0001;
        push_vote(0);
        step(HOLD);
        finish_vote(1'b0);
        read_tally(0, 1);
        read_tally(1, 1);

        // Changed pattern restarts the hold
        open_ballot();
        vote_btn = 4'b0001;
        step(2);
        vote_btn = 4'b0100;
        push_vote(2);
        step(HOLD);
        finish_vote(1'b0);
        read_tally(0, 1);
        read_tally(2, 1);

        // Button held through ACK: no second ballot until released and re-authorised
        open_ballot();
        vote_btn = 4'b1000;
        push_vote(3);
        step(HOLD);
        finish_vote(1'b1);
        ballot_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("held_release_ready", 32'(ready), 0);
        end
        ballot_en = 1'b0;
        vote_btn  = '0;
        step(1);
        vote_btn  = 4'b0001;
        ballot_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("idle_btn_held_ready", 32'(ready), 0);
        end
        ballot_en = 1'b0;
        vote_btn  = '0;
        step(1);
        read_tally(3, 1);

        // Saturate candidate 3, then reject it
        for (int i = 0; i < 14; i++) do_vote(4'b1000, 3);
        check("cand_full", 32'(cand_full), 32'h8);
        read_tally(3, 15);
        open_ballot();
        vote_btn = 4'b1000;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("full_invalid", 32'(invalid), 1);
            step(1);
        end
        check("full_ready", 32'(ready), 1);
        vote_btn = 4'b0001;
        push_vote(0);
        step(HOLD);
        finish_vote(1'b0);
        read_tally(3, 15);
        read_tally(0, 2);

        // Build tallies {2,1,0,5} from a clean start, then reset mid-ACK
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        do_vote(4'b0001, 0);
        do_vote(4'b0001, 0);
        do_vote(4'b0010, 1);
        for (int i = 0; i < 5; i++) do_vote(4'b1000, 3);
        read_tally(0, 2);
        read_tally(1, 1);
        read_tally(2, 0);
        read_tally(3, 5);
        open_ballot();
        vote_btn = 4'b0001;
        step(HOLD);
        step(2);
        check("in_ack", 32'(vote_ack), 1);
        reset = 1'b1;
        step(1);
        reset    = 1'b0;
        vote_btn = '0;
        for (int i = 0; i < 4; i++) model[i] = 0;
        check("midrst_ready", 32'(ready), 0);
        check("midrst_vote_ack", 32'(vote_ack), 0);
        check("midrst_total", 32'(total_votes), 0);
        check("midrst_cand_full", 32'(cand_full), 0);
        for (int i = 0; i < 4; i++) read_tally(i, 0);
        do_vote(4'b0010, 1);
        read_tally(1, 1);

        step(3);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
